// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 width codes, bridge states, lane helpers.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } lsu_state_t;

    // Byte offset of the addressed item within the word.
    typedef logic [1:0] lane_t;

    // Halfword/word offsets have their low bits forced to zero.
    function automatic lane_t lane_sel(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: lane_sel = a;
            F3_H, F3_HU: lane_sel = {a[1], 1'b0};
            default:     lane_sel = 2'b00;
        endcase
    endfunction

    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        if (wr) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else    f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: misaligned = a[0];
            F3_W:        misaligned = (a != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: byte enables and store replication, plus
// load extraction with sign/zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    lane_t       lane;
    logic [31:0] sh;

    assign lane = lane_sel(funct3_i, addr_i);
    assign sh   = rdata_i >> {lane, 3'b000};

    always_comb begin
        be_o      = 4'b0000;
        wdata_o   = wdata_i;
        ld_data_o = 32'h0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << lane;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                be_o    = 4'b0011 << lane;
                wdata_o = {2{wdata_i[15:0]}};
            end
            F3_W:    be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
        case (funct3_i)
            F3_B:    ld_data_o = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   ld_data_o = {24'h0, sh[7:0]};
            F3_H:    ld_data_o = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   ld_data_o = {16'h0, sh[15:0]};
            F3_W:    ld_data_o = rdata_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_bridge.sv
// Single-outstanding load/store bridge to a word memory with variable-latency ack.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.
module lsu_bridge
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q;
    lane_t       lo_q;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        err_q;

    logic        accept, acc_err, timed_out;
    logic [2:0]  al_f3;
    logic [1:0]  al_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ld;

    assign accept    = (state_q == S_IDLE) && req_valid;
    assign timed_out = (cnt_q == TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_err = !f3_legal(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
    assign acc_err = !f3_legal(req_write, req_funct3);
`endif

    // One aligner serves the store path in IDLE and the load path from latched fields.
    assign al_f3   = (state_q == S_IDLE) ? req_funct3 : f3_q;
    assign al_addr = (state_q == S_IDLE) ? req_addr[1:0] : lo_q;

    lsu_align u_align (
        .funct3_i  (al_f3),
        .addr_i    (al_addr),
        .wdata_i   (req_wdata),
        .rdata_i   (mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ld_data_o (al_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                cnt_d     = 8'h0;
                if (req_valid) state_d = acc_err ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                mem_req = 1'b1;
                cnt_d   = cnt_q + 8'h1;
                if (mem_ack || timed_out) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            f3_q    <= req_funct3;
            lo_q    <= req_addr[1:0];
            we_q    <= req_write;
            addr_q  <= {req_addr[31:2], 2'b00};
            be_q    <= al_be;
            wdata_q <= al_wdata;
            if (acc_err) begin
                err_q   <= 1'b1;
                rdata_q <= 32'h0;
            end
        end else if (state_q == S_ISSUE) begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (mem_ack) begin
                err_q   <= 1'b0;
                rdata_q <= we_q ? 32'h0 : al_ld;
            end else if (timed_out) begin
                err_q   <= 1'b1;
                rdata_q <= 32'h0;
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_bridge.sv
// Scoreboard bench for lsu_bridge: driver pushes expected responses from a byte-level
// reference model, a monitor pops them on rsp_valid, a responder plays the memory.
module tb_lsu_bridge;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    lsu_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // memory-side expectations for the transaction currently in flight
    int          r_delay;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we, r_illegal;
    logic        late_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        return (a % 4) / m_size(f3) * m_size(f3);
    endfunction

    function automatic logic m_illegal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        bad = wr ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
        if (!bad && (a % m_size(f3)) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int n, off;
        logic [31:0] v;
        n = m_size(f3); off = m_off(f3, a); v = 0;
        for (int i = 0; i < n; i++) v = v + (32'(w[8*(off+i) +: 8]) << (8*i));
        if (f3[2] == 1'b0 && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] b;
        b = 0;
        for (int i = 0; i < m_size(f3); i++) b[m_off(f3, a) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = d[8*(i % m_size(f3)) +: 8];
        return v;
    endfunction

    // memory responder: acks on the r_delay-th cycle of mem_req, stray acks otherwise
    initial begin
        int icnt;
        icnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                icnt++;
                chk("mem_req_on_illegal", {31'b0, mem_req}, {31'b0, !r_illegal});
                if (icnt == r_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = r_rdata;
                    chk("mem_addr", mem_addr, r_addr);
                    chk("mem_be", {28'b0, mem_be}, {28'b0, r_be});
                    chk("mem_we", {31'b0, mem_we}, {31'b0, r_we});
                    if (r_we) chk("mem_wdata", mem_wdata, r_wdata);
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                icnt = 0;
                mem_ack = late_ack || ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_rsp: rsp_valid with no outstanding request (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly);
        exp_t e;
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: bridge never became ready (cycle %0d)", cyc);
        end
        r_illegal = m_illegal(wr, f3, a);
        r_delay = dly; r_rdata = rd; r_we = wr;
        r_addr = {a[31:2], 2'b00};
        r_be = m_be(f3, a);
        r_wdata = m_wdata(f3, wd);
        e.acc = cyc;
        if (r_illegal) begin
            e.err = 1'b1; e.rdata = 0; e.lat = 1;
        end else if (dly <= TO) begin
            e.err = 1'b0; e.rdata = wr ? 32'h0 : m_load(f3, a, rd); e.lat = dly + 1;
        end else begin
            e.err = 1'b1; e.rdata = 0; e.lat = TO + 1;
        end
        sbq.push_back(e);
        if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        logic [2:0] f3s[5];
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 0; req_wdata = 0;
        r_delay = 0; r_rdata = 0; r_addr = 0; r_wdata = 0; r_be = 0; r_we = 0; r_illegal = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        issue(1'b1, 3'd0, 32'h1003, 32'h0000_00A5, 32'h0, 3);
        issue(1'b0, 3'd0, 32'h2001, 32'h0, 32'h0000_8000, 1);
        issue(1'b0, 3'd4, 32'h2001, 32'h0, 32'h0000_8000, 2);
        issue(1'b0, 3'd5, 32'h2002, 32'h0, 32'hBEEF_1234, 1);
        issue(1'b0, 3'd2, 32'h3002, 32'h0, 32'hCAFE_F00D, 2);
        issue(1'b0, 3'd1, 32'h4003, 32'h0, 32'h8123_4567, 1);
        issue(1'b0, 3'd2, 32'h5000, 32'h0, 32'h1234_5678, 99);
        issue(1'b0, 3'd2, 32'h5004, 32'h0, 32'h8765_4321, TO);
        issue(1'b1, 3'd4, 32'h6000, 32'h1111_2222, 32'h0, 1);
        issue(1'b1, 3'd1, 32'h6006, 32'h0000_BEEF, 32'h0, 1);
        issue(1'b0, 3'd3, 32'h6008, 32'h0, 32'h0, 1);

        for (int i = 0; i < 200; i++) begin
            logic [2:0] f3;
            int dly, sel;
            f3 = ($urandom_range(0, 9) < 8) ? f3s[$urandom_range(0, 4)] : 3'($urandom);
            sel = $urandom_range(0, 9);
            dly = (sel < 7) ? $urandom_range(1, 5) : (sel < 9) ? $urandom_range(TO - 1, TO + 1) : 40;
            issue(1'($urandom), f3, $urandom, $urandom, $urandom, dly);
        end

        @(negedge clk);
        req_valid = 1'b0;
        for (int g = 0; g < 60 && sbq.size() != 0; g++) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        // reset in the 2nd ISSUE cycle discards the access
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h7000;
        r_illegal = 1'b0; r_delay = 1000; r_we = 1'b0; r_addr = 32'h7000; r_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("issue_mem_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late_ack = 1'b1;
        chk("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        late_ack = 1'b0;
        chk("post_rst_idle_mem_req", {31'b0, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
